// File: rtl/crc_frame_scheduler.sv
// crc_frame_scheduler: round-robin arbiter feeding two requesters' codewords to a shared CRC decoder.
module crc_frame_scheduler #(
   parameter int INPUT_BITS  = 20,
   parameter int OUTPUT_BITS = INPUT_BITS - 4,
   parameter int TIMEOUT     = 64
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   req0_valid,
   input  logic [INPUT_BITS-1:0]  req0_data,
   output logic                   req0_ready,
   input  logic                   req1_valid,
   input  logic [INPUT_BITS-1:0]  req1_data,
   output logic                   req1_ready,
   output logic                   dec_start,
   output logic [INPUT_BITS-1:0]  dec_data,
   input  logic                   dec_ready,
   input  logic                   dec_valid,
   input  logic [OUTPUT_BITS-1:0] dec_out,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [OUTPUT_BITS-1:0] res_data,
   output logic                   res_ok,
   output logic                   res_timeout,
   output logic                   res_src,
   output logic [15:0]            err_count
);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [TW-1:0] timer;
   logic last_grant, gnt, hs, tmo, fin, fail;
   assign gnt  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   assign hs   = (state == IDLE) & (req0_valid | req1_valid);
   assign tmo  = timer == TW'(TIMEOUT - 1);
   // a late dec_ready on the final RUN cycle still beats the timeout
   assign fin  = (state == RUN) & (dec_ready | tmo);
   assign fail = dec_ready ? ~dec_valid : 1'b1;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = hs ? LOAD : IDLE;
         LOAD: state_nx = RUN;
         RUN:  state_nx = fin ? DONE : RUN;
         DONE: state_nx = res_ready ? IDLE : DONE;
      endcase
   end
   always_comb begin
      req0_ready = resetn & hs & ~gnt;
      req1_ready = resetn & hs & gnt;
      dec_start  = state == RUN;
      res_valid  = state == DONE;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dec_data    <= '0;
         res_src     <= 1'b0;
         res_data    <= '0;
         res_ok      <= 1'b0;
         res_timeout <= 1'b0;
         timer       <= '0;
         last_grant  <= 1'b1;
         err_count   <= '0;
      end else begin
         if (hs) begin
            dec_data <= gnt ? req1_data : req0_data;
            res_src  <= gnt;
         end
         if (state == LOAD) timer <= '0;
         if (state == RUN) timer <= timer + TW'(1);
         if (fin) begin
            res_data    <= dec_ready ? dec_out : '0;
            res_ok      <= dec_ready & dec_valid;
            res_timeout <= ~dec_ready;
         end
         if (fin && fail && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         if (state == DONE && res_ready) last_grant <= res_src;
      end
   end
endmodule
